step_pacer: RTL and testbench



---
 rtl/step_pacer.sv | 165 ++++++++++++++++
 tb/tb_step_pacer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/step_pacer.sv
// Step strobe generator for the one-hot ring: free-run prescaler or debounced single-step.
// Optional STEP_PACER_SYNC_EN adds 2-flop synchronizers on both raw buttons.
module step_pacer #(
    parameter int unsigned CNT_W     = 26,
    parameter int unsigned BASE_DIV  = 1000,
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned RING_LEN  = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    input  logic [3:0]                  div_sel,
    input  logic                        pause_btn,
    input  logic                        step_btn,
    output logic                        step_pulse,
    output logic [$clog2(RING_LEN)-1:0] phase,
    output logic                        wrap,
    output logic                        running
);

    localparam int unsigned PhW = $clog2(RING_LEN);
    localparam int unsigned DbW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    typedef enum logic [0:0] {StRun, StPaused} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, period_m1;
    logic [PhW-1:0]       phase_q, phase_d;
    logic                 pulse_q, pulse_d;
    logic                 wrap_q, wrap_d;
    logic [3:0]           shadow_q, shadow_d;
    logic [1:0]           btn_raw;
    logic [1:0]           stable_q, stable_d;
    logic [1:0]           press_q, press_d;
    logic [1:0][DbW-1:0]  db_cnt_q, db_cnt_d;
    logic                 pause_ev, step_ev, fire;

    // Bit 0 is the pause button, bit 1 the step button throughout.
`ifdef STEP_PACER_SYNC_EN
    logic [1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {step_btn, pause_btn};
            sync2_q <= sync1_q;
        end
    end

    assign btn_raw = sync2_q;
`else
    assign btn_raw = {step_btn, pause_btn};
`endif

    always_comb begin
        stable_d = stable_q;
        press_d  = '0;
        db_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (btn_raw[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DbW'(DB_CYCLES - 1)) begin
                    stable_d[i] = btn_raw[i];
                    press_d[i]  = btn_raw[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    // Presses seen while the tile is disabled are dropped, not deferred.
    assign pause_ev  = press_q[0] & ena;
    assign step_ev   = press_q[1] & ena;
    assign period_m1 = (CNT_W'(BASE_DIV) << shadow_q) - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (pause_ev) begin
            state_d = (state_q == StRun) ? StPaused : StRun;
        end
    end

    always_comb begin
        running = (state_q == StRun);
    end

    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        fire     = 1'b0;
        if (ena) begin
            shadow_d = div_sel;
            if (state_q == StRun) begin
                if (cnt_q == period_m1) begin
                    cnt_d = '0;
                    fire  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (pause_ev) begin
                    cnt_d = '0;
                end
            end else begin
                cnt_d = '0;
                fire  = step_ev & ~pause_ev;
            end
            // A period change restarts the count and swallows this cycle's pulse.
            if (shadow_q != div_sel) begin
                cnt_d = '0;
                fire  = 1'b0;
            end
        end
    end

    always_comb begin
        pulse_d = fire;
        wrap_d  = 1'b0;
        phase_d = phase_q;
        if (fire) begin
            if (phase_q == PhW'(RING_LEN - 1)) begin
                phase_d = '0;
                wrap_d  = 1'b1;
            end else begin
                phase_d = phase_q + PhW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            phase_q  <= '0;
            pulse_q  <= 1'b0;
            wrap_q   <= 1'b0;
            shadow_q <= div_sel;
            stable_q <= '0;
            press_q  <= '0;
            db_cnt_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            pulse_q  <= pulse_d;
            wrap_q   <= wrap_d;
            shadow_q <= shadow_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign step_pulse = pulse_q;
    assign phase      = phase_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_step_pacer.sv
// Scoreboard bench for step_pacer: expected pulses (cycle, phase, wrap) are queued as stimulus
// is driven and popped whenever the DUT strobes step_pulse.
module tb_step_pacer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [3:0] div_sel = 4'd0;
    logic       pause_btn = 1'b0;
    logic       step_btn = 1'b0;
    logic       step_pulse;
    logic [2:0] phase;
    logic       wrap;
    logic       running;

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        int unsigned cyc;
        int unsigned ph;
        int unsigned wr;
    } exp_t;

    exp_t exp_q[$];

    step_pacer #(
        .CNT_W    (26),
        .BASE_DIV (4),
        .DB_CYCLES(3),
        .RING_LEN (5)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .div_sel   (div_sel),
        .pause_btn (pause_btn),
        .step_btn  (step_btn),
        .step_pulse(step_pulse),
        .phase     (phase),
        .wrap      (wrap),
        .running   (running)
    );

    always #5 clk = ~clk;

    // cyc equals the number of rising edges seen; read it on the falling edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_exp(input int unsigned c, input int unsigned p, input int unsigned w);
        exp_t e;
        e.cyc = c;
        e.ph  = p;
        e.wr  = w;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    // Returns the index of the reset edge; outputs are sampled right after it.
    task automatic do_reset(output int unsigned r);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        r = cyc;
    endtask

    always @(negedge clk) begin
        if (step_pulse === 1'b1) begin
            check_eq("pulse_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("pulse_cyc", cyc, e.cyc);
                check_eq("pulse_phase", phase, e.ph);
                check_eq("pulse_wrap", wrap, e.wr);
            end
        end else if (wrap === 1'b1) begin
            check_eq("wrap_without_pulse", wrap, 0);
        end
    end

    initial begin
        int unsigned r, m, b, c;

        // Free run from reset: period 4, phase 1..4 then wrap to 0.
        do_reset(r);
        check_eq("rst_pulse", step_pulse, 0);
        check_eq("rst_phase", phase, 0);
        check_eq("rst_wrap", wrap, 0);
        check_eq("rst_running", running, 1);
        for (int k = 1; k <= 5; k++) begin
            push_exp(r + 4 * k, k % 5, (k == 5) ? 1 : 0);
        end
        wait_until(r + 22);
        check_eq("freerun_missing", exp_q.size(), 0);

        // Divider change with cnt=2: old terminal count swallowed, then period 16.
        div_sel = 4'd2;
        m = r + 23;
        push_exp(m + 16, 1, 0);
        push_exp(m + 32, 2, 0);
        wait_until(m + 34);
        check_eq("div_missing", exp_q.size(), 0);
        div_sel = 4'd0;

        // Pause press lands on a terminal count: that pulse still issues.
        do_reset(r);
        wait_until(r + 1);
        pause_btn = 1'b1;
        push_exp(r + 4, 1, 0);
        wait_until(r + 4);
        pause_btn = 1'b0;
        wait_until(r + 6);
        check_eq("pause_running", running, 0);
        wait_until(r + 106);
        check_eq("pause_hold_running", running, 0);
        check_eq("pause_hold_phase", phase, 1);
        check_eq("pause_missing", exp_q.size(), 0);

        // Single step press held 3 cycles.
        wait_until(r + 110);
        step_btn = 1'b1;
        push_exp(r + 114, 2, 0);
        wait_until(r + 113);
        step_btn = 1'b0;
        wait_until(r + 116);
        check_eq("step_missing", exp_q.size(), 0);
        check_eq("step_phase", phase, 2);

        // Bounce: toggle every cycle, never stable for 3 samples.
        b = r + 120;
        for (int i = 0; i < 12; i++) begin
            wait_until(b + i);
            step_btn = (i % 2 == 0);
        end
        wait_until(b + 12);
        step_btn = 1'b0;
        wait_until(b + 20);
        check_eq("bounce_phase", phase, 2);
        check_eq("bounce_running", running, 0);

        // Simultaneous pause and step: resume wins, step dropped.
        c = r + 140;
        wait_until(c);
        pause_btn = 1'b1;
        step_btn  = 1'b1;
        push_exp(c + 8, 3, 0);
        wait_until(c + 3);
        pause_btn = 1'b0;
        step_btn  = 1'b0;
        wait_until(c + 4);
        check_eq("simul_running", running, 1);
        check_eq("simul_phase", phase, 2);
        wait_until(c + 9);
        check_eq("simul_missing", exp_q.size(), 0);

        // Reset mid-run at phase 3, cnt 2.
        wait_until(c + 10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        r = cyc;
        check_eq("midrst_phase", phase, 0);
        check_eq("midrst_pulse", step_pulse, 0);
        check_eq("midrst_wrap", wrap, 0);
        check_eq("midrst_running", running, 1);
        push_exp(r + 4, 1, 0);

        // ena low freezes the count and drops a pause press.
        wait_until(r + 5);
        ena = 1'b0;
        wait_until(r + 6);
        pause_btn = 1'b1;
        wait_until(r + 9);
        pause_btn = 1'b0;
        wait_until(r + 14);
        check_eq("ena_phase", phase, 1);
        check_eq("ena_running", running, 1);
        wait_until(r + 15);
        ena = 1'b1;
        push_exp(r + 18, 2, 0);
        wait_until(r + 20);
        check_eq("ena_missing", exp_q.size(), 0);
        check_eq("ena_end_running", running, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
